// File: rtl/bram_burst_reader_if.sv
// Command and output-stream bundle of the BRAM burst reader.
// The slave modport is the reader's view; master is the command source / stream sink.
interface bram_burst_reader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 18
);
  logic              cmd_valid_in;
  logic              cmd_ready_out;
  logic [ADDR_W-1:0] cmd_addr_in;
  logic [ADDR_W:0]   cmd_len_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              last_out;
  logic              ready_in;

  modport slave (
    input  cmd_valid_in, cmd_addr_in, cmd_len_in, ready_in,
    output cmd_ready_out, data_out, valid_out, last_out
  );

  modport master (
    output cmd_valid_in, cmd_addr_in, cmd_len_in, ready_in,
    input  cmd_ready_out, data_out, valid_out, last_out
  );
endinterface

// File: rtl/bram_burst_reader.sv
// Burst read engine for BRAM port B: sequential reads, latency absorbed in a
// credit-checked FIFO, results presented as a valid/ready stream with a last flag.
module bram_burst_reader #(
  parameter int unsigned RAM_WIDTH    = 18,
  parameter int unsigned RAM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned ADDR_W      = $clog2(RAM_DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  bram_burst_reader_if.slave    bus,
  output logic [ADDR_W-1:0]     ram_addr_out,
  output logic                  ram_en_out,
  output logic                  ram_regce_out,
  input  logic [RAM_WIDTH-1:0]  ram_dout_in,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic                 last;
    logic [RAM_WIDTH-1:0] data;
  } entry_t;

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        rem;
  logic                    ram_last;
  logic [READ_LATENCY-1:0] vld_sr, last_sr;
  entry_t                  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_count, inflight;

  logic                    accept_c, issue_c, push_c, pop_c, credit_c, done_c;
  logic [CNT_W-1:0]        count_nxt_c;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(RAM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept_c      = bus.cmd_valid_in & bus.cmd_ready_out;
  assign push_c        = vld_sr[READ_LATENCY-1];
  assign pop_c         = bus.valid_out & bus.ready_in;
  assign count_nxt_c   = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
  // Credit counts every read decided but not yet pushed, so the FIFO can never overflow.
  assign credit_c      = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH);
  assign ram_regce_out = 1'b1;

  assign bus.data_out  = fifo_mem[rd_ptr].data;
  assign bus.last_out  = fifo_mem[rd_ptr].last;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = (bus.cmd_len_in == '0) ? DRAIN : ISSUE;
      ISSUE:   if ((rem == '0) || (issue_c && (rem == LEN_W'(1)))) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && (fifo_count == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: the first read goes out on the accept edge, later ones need credit.
  always_comb begin
    issue_c = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE:    issue_c = accept_c && (bus.cmd_len_in != '0);
      ISSUE:   issue_c = credit_c && (rem != '0);
      DRAIN:   done_c  = (state_nxt == IDLE);
      default: ;
    endcase
  end

  // Control, issue, return-path and FIFO bookkeeping registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.cmd_ready_out <= 1'b1;
      bus.valid_out     <= 1'b0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
      ram_en_out        <= 1'b0;
      ram_addr_out      <= '0;
      ram_last          <= 1'b0;
      rem               <= '0;
      vld_sr            <= '0;
      last_sr           <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_count        <= '0;
      inflight          <= '0;
    end else begin
      bus.cmd_ready_out <= (state_nxt == IDLE);
      busy_out          <= (state_nxt != IDLE);
      done_out          <= done_c;
      ram_en_out        <= issue_c;
      if (accept_c) begin
        ram_addr_out <= bus.cmd_addr_in;
        rem          <= (bus.cmd_len_in == '0) ? '0 : bus.cmd_len_in - LEN_W'(1);
        ram_last     <= (bus.cmd_len_in == LEN_W'(1));
      end else if (issue_c) begin
        ram_addr_out <= addr_inc(ram_addr_out);
        rem          <= rem - LEN_W'(1);
        ram_last     <= (rem == LEN_W'(1));
      end
      vld_sr[0]  <= ram_en_out;
      last_sr[0] <= ram_en_out & ram_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      inflight <= inflight + CNT_W'(issue_c) - CNT_W'(push_c);
      if (push_c) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_c)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count    <= count_nxt_c;
      bus.valid_out <= (count_nxt_c != '0);
    end
  end

  // FIFO storage; occupancy is tracked by the counters, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (push_c) fifo_mem[wr_ptr] <= '{last: last_sr[READ_LATENCY-1], data: ram_dout_in};
  end

endmodule
